// File: rtl/width_enum_pkg.sv
// Shared definitions for the enum-code sequencer: legal codes, FSM encoding,
// and helpers for code legality and sequence order.
package width_enum_pkg;

  localparam logic [3:0] E0 = 4'h0;
  localparam logic [3:0] E1 = 4'h5;
  localparam logic [3:0] E2 = 4'h6;
  localparam logic [3:0] E3 = 4'h7;
  localparam logic [3:0] E4 = 4'hA;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } state_e;

  function automatic logic code_legal(input logic [3:0] code);
    logic legal;
    case (code)
      E0, E1, E2, E3, E4: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
    return legal;
  endfunction

  // E4 wraps to E0; callers detect the end of sequence separately.
  function automatic logic [3:0] next_code(input logic [3:0] code);
    logic [3:0] nxt;
    case (code)
      E0:      nxt = E1;
      E1:      nxt = E2;
      E2:      nxt = E3;
      E3:      nxt = E4;
      default: nxt = E0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/width_enum_dwell.sv
// Dwell counter: counts enabled cycles and signals wrap on the last of h cycles.
module width_enum_dwell #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] h,
  output logic               wrap
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign wrap = enable && (cnt_q == (h - DWELL_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/width_enum_seq.sv
// Enum-code sequencer: steps E0..E4 with a programmable dwell per code,
// supports stall, jump-by-load, and an error state on illegal jump targets.
module width_enum_seq
  import width_enum_pkg::*;
#(
  parameter int unsigned CODE_W  = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] hold_len,
  input  logic               stall,
  input  logic               load_valid,
  input  logic [CODE_W-1:0]  load_code,
  output logic [CODE_W-1:0]  code_out,
  output logic               code_valid,
  output logic               is_e2,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [DWELL_W-1:0] h_q, h_d;
  logic               start_ok;
  logic               dwell_clr;
  logic               dwell_en;
  logic               dwell_wrap;

  assign start_ok  = start && ((state_q == StIdle) || (state_q == StErr));
  // A load overrides stall and the normal advance, so it also suppresses counting.
  assign dwell_clr = start_ok || ((state_q == StRun) && load_valid);
  assign dwell_en  = (state_q == StRun) && !stall && !load_valid;

  width_enum_dwell #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (dwell_clr),
    .enable (dwell_en),
    .h      (h_q),
    .wrap   (dwell_wrap)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    h_d     = h_q;
    unique case (state_q)
      StIdle, StErr: begin
        code_d = E0;
        if (start) begin
          state_d = StRun;
          h_d     = (hold_len == '0) ? DWELL_W'(1) : hold_len;
        end
      end
      StRun: begin
        if (load_valid) begin
          if (code_legal(load_code)) begin
            code_d = load_code;
          end else begin
            state_d = StErr;
            code_d  = E0;
          end
        end else if (dwell_wrap) begin
          if (code_q == E4) begin
            state_d = StDone;
            code_d  = E0;
          end else begin
            code_d = next_code(code_q);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        code_d  = E0;
      end
      default: begin
        state_d = StIdle;
        code_d  = E0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      code_q  <= E0;
      h_q     <= DWELL_W'(1);
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      h_q     <= h_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = (state_q == StRun);
  assign is_e2      = (code_q == E2) && code_valid;
  assign busy       = (state_q == StRun) || (state_q == StDone);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);

endmodule

// File: tb/tb_width_enum_seq.sv
// Self-checking bench for width_enum_seq: directed scenarios plus randomized
// stimulus against a sequence-index/remaining-dwell reference model.
module tb_width_enum_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] hold_len;
  logic       stall;
  logic       load_valid;
  logic [3:0] load_code;
  logic [3:0] code_out;
  logic       code_valid;
  logic       is_e2;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int failures;

  width_enum_seq #(
    .CODE_W  (4),
    .DWELL_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold_len   (hold_len),
    .stall      (stall),
    .load_valid (load_valid),
    .load_code  (load_code),
    .code_out   (code_out),
    .code_valid (code_valid),
    .is_e2      (is_e2),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode, position in the code list, cycles left on this code.
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MDone = 2;
  localparam int MErr  = 3;

  logic [3:0] seq [5] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'hA};

  int m_mode;
  int m_idx;
  int m_left;
  int m_h;

  function automatic int find_code(input logic [3:0] c);
    for (int i = 0; i < 5; i++) begin
      if (seq[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = MIdle;
    m_idx  = 0;
    m_left = 1;
    m_h    = 1;
  endtask

  task automatic model_step();
    int k;
    case (m_mode)
      MIdle, MErr: begin
        if (start) begin
          m_mode = MRun;
          m_idx  = 0;
          m_h    = (hold_len == 4'd0) ? 1 : int'(hold_len);
          m_left = m_h;
        end
      end
      MRun: begin
        if (load_valid) begin
          k = find_code(load_code);
          if (k < 0) begin
            m_mode = MErr;
          end else begin
            m_idx  = k;
            m_left = m_h;
          end
        end else if (!stall) begin
          if (m_left > 1) begin
            m_left--;
          end else if (m_idx == 4) begin
            m_mode = MDone;
          end else begin
            m_idx++;
            m_left = m_h;
          end
        end
      end
      default: m_mode = MIdle;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    start      = 1'b0;
    hold_len   = 4'd0;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_code  = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Advance until code_out shows c while valid; ok=0 if the bound expires.
  task automatic wait_code(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (code_valid && code_out == c) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (code_out !== 4'h0 || code_valid !== 1'b0 || is_e2 !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got code=%h valid=%b e2=%b busy=%b done=%b err=%b, want 0/0/0/0/0/0",
               code_out, code_valid, is_e2, busy, done, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (code_out !== 4'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got code=%h busy=%b, want 0/0", code_out, busy);
    end
  endtask

  task automatic test_hold2();
    logic [3:0] exp [10] = '{4'h0, 4'h0, 4'h5, 4'h5, 4'h6, 4'h6, 4'h7, 4'h7, 4'hA, 4'hA};
    do_reset();
    start = 1'b1;
    hold_len = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (code_out !== exp[i] || code_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL hold2_seq[%0d]: got code=%h valid=%b busy=%b done=%b, want code=%h valid=1 busy=1 done=0",
                 i, code_out, code_valid, busy, done, exp[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold2_done: got done=%b valid=%b, want done=1 valid=0", done, code_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold2_idle: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_hold0();
    int e2_cnt;
    e2_cnt = 0;
    do_reset();
    start = 1'b1;
    hold_len = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (is_e2) e2_cnt++;
      checks++;
      if (code_out !== seq[i] || code_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold0_seq[%0d]: got code=%h valid=%b, want code=%h valid=1",
                 i, code_out, code_valid, seq[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL hold0_done: got done=%b, want 1", done);
    end
    checks++;
    if (e2_cnt != 1) begin
      failures++;
      $display("FAIL hold0_is_e2_cycles: got %0d, want 1", e2_cnt);
    end
  endtask

  task automatic test_stall();
    int e1_cnt;
    int stall_left;
    int done_at;
    e1_cnt = 0;
    stall_left = 4;
    done_at = -1;
    do_reset();
    start = 1'b1;
    hold_len = 4'd3;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      if (code_valid && code_out == 4'h5) e1_cnt++;
      if (e1_cnt >= 1 && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
      end
      tick();
    end
    stall = 1'b0;
    checks++;
    if (e1_cnt != 7) begin
      failures++;
      $display("FAIL stall_e1_cycles: got %0d, want 7", e1_cnt);
    end
    checks++;
    if (done_at != 20) begin
      failures++;
      $display("FAIL stall_done_cycle: got %0d, want 20", done_at);
    end
  endtask

  task automatic test_load();
    bit ok;
    int e4_cnt;
    bit saw_done;
    do_reset();
    start = 1'b1;
    hold_len = 4'd2;
    tick();
    start = 1'b0;
    wait_code(4'h5, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL load_wait_e1: got timeout, want E1");
    end
    load_valid = 1'b1;
    load_code  = 4'hA;
    tick();
    load_valid = 1'b0;
    e4_cnt = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (code_valid && code_out == 4'hA) e4_cnt++;
      tick();
    end
    checks++;
    if (e4_cnt != 2 || !saw_done) begin
      failures++;
      $display("FAIL load_legal: got e4_cycles=%0d done=%b, want 2/1", e4_cnt, saw_done);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_code(4'h5, ok);
    load_valid = 1'b1;
    load_code  = 4'h3;
    tick();
    load_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || code_out !== 4'h0 || busy !== 1'b0 || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_illegal: got err=%b code=%h busy=%b valid=%b, want 1/0/0/0",
               err, code_out, busy, code_valid);
    end
    // A legal load must be ignored while in the error state.
    load_valid = 1'b1;
    load_code  = 4'h6;
    tick();
    tick();
    load_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || code_out !== 4'h0 || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_hold: got err=%b code=%h valid=%b, want 1/0/0", err, code_out, code_valid);
    end
    start = 1'b1;
    hold_len = 4'd1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || code_out !== 4'h0 || code_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_restart: got err=%b code=%h valid=%b busy=%b, want 0/0/1/1",
               err, code_out, code_valid, busy);
    end
    tick();
    checks++;
    if (code_out !== 4'h5) begin
      failures++;
      $display("FAIL err_restart_e1: got code=%h, want 5", code_out);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bit saw_done;
    do_reset();
    start = 1'b1;
    hold_len = 4'd3;
    tick();
    start = 1'b0;
    wait_code(4'h6, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_wait_e2: got timeout, want E2");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (code_out !== 4'h0 || code_valid !== 1'b0 || is_e2 !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got code=%h valid=%b e2=%b busy=%b done=%b err=%b, want all 0",
               code_out, code_valid, is_e2, busy, done, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL midrst_no_done: got done/busy activity=1, want 0");
    end
    start = 1'b1;
    hold_len = 4'd2;
    tick();
    start = 1'b0;
    checks++;
    if (code_out !== 4'h0 || code_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart: got code=%h valid=%b, want 0/1", code_out, code_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_code;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start      = ($urandom_range(0, 7) == 0);
      hold_len   = 4'($urandom_range(0, 4));
      stall      = ($urandom_range(0, 3) == 0);
      load_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) load_code = seq[$urandom_range(0, 4)];
      else load_code = 4'($urandom_range(0, 15));
      tick();
      exp_code = (m_mode == MRun) ? seq[m_idx] : 4'h0;
      if (m_mode != MDone) begin
        checks++;
        if (code_out !== exp_code) begin
          failures++;
          $display("FAIL rand_code cyc=%0d: got %h, want %h", cyc, code_out, exp_code);
        end
      end
      checks++;
      if (code_valid !== (m_mode == MRun) || busy !== (m_mode == MRun || m_mode == MDone) ||
          done !== (m_mode == MDone) || err !== (m_mode == MErr) ||
          is_e2 !== (m_mode == MRun && exp_code == 4'h6)) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d: got valid=%b busy=%b done=%b err=%b e2=%b, model mode=%0d code=%h",
                 cyc, code_valid, busy, done, err, is_e2, m_mode, exp_code);
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    test_reset();
    test_hold2();
    test_hold0();
    test_stall();
    test_load();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/width_enum_seq.md
WIDTH_ENUM_SEQ -- requirements
Module: width_enum_seq

Interface
REQ-001 SHALL have parameter: CODE_W, 4, width of enum code bus (fixed at 4; other values unsupported).
REQ-002 SHALL have parameter: DWELL_W, 4, width of dwell-length input and dwell counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: start  input  1  begin a sequence run; sampled only in IDLE or ERR.
REQ-006 SHALL have port: hold_len  input  DWELL_W  dwell cycles per code, latched on accepted start; 0 treated as 1.
REQ-007 SHALL have port: stall  input  1  freeze dwell counter and code while high.
REQ-008 SHALL have port: load_valid  input  1  request jump to load_code during RUN.
REQ-009 SHALL have port: load_code  input  CODE_W  target code for jump.
REQ-010 SHALL have port: code_out  output  CODE_W  current enum code driven to the datapath.
REQ-011 SHALL have port: code_valid  output  1  code_out meaningful (high in RUN only).
REQ-012 SHALL have port: is_e2  output  1  combinational (code_out == E2) && code_valid.
REQ-013 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at end of sequence.
REQ-015 SHALL have port: err  output  1  high in ERR state.

Function
REQ-016 SHALL use legal codes E0=4'h0, E1=4'h5, E2=4'h6, E3=4'h7, E4=4'hA; sequence order E0->E1->E2->E3->E4.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE, ERR.
REQ-018 IDLE: start=1 -> RUN next cycle, code_out=E0, dwell count=0, H=max(hold_len,1) latched.
REQ-019 RUN: each code held exactly H non-stalled cycles; counter increments per non-stalled cycle, advances code and clears at H-1.
REQ-020 RUN: after E4 completes dwell -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-021 Unstalled run latency: start accepted at edge n -> code_valid from n+1, done high in cycle n+1+5H.
REQ-022 stall=1: counter, code_out and state unchanged; stall has no effect outside RUN.
REQ-023 RUN with load_valid=1 and legal load_code: next cycle code_out=load_code, counter cleared; sequence continues from that code.
REQ-024 RUN with load_valid=1 and illegal load_code: next cycle ERR, code_out=E0, code_valid=0, busy=0, err=1.
REQ-025 load_valid and stall in the same cycle: load takes priority.
REQ-026 load_valid in RUN on the final E4 dwell cycle: load wins over the DONE transition.
REQ-027 start ignored in RUN and DONE; load_valid ignored outside RUN.
REQ-028 ERR: err held until start=1, which clears err and enters RUN exactly as from IDLE.
REQ-029 In IDLE and ERR, code_out SHALL be E0.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE, code_out=E0, counter=0, latched H=1, and code_valid, is_e2, busy, done, err all 0.
REQ-031 Reset asserted mid-run SHALL abort with no done pulse; the first start after deassertion SHALL begin from E0.

Structure
REQ-032 Package width_enum_pkg SHALL hold E0..E4 constants, FSM state encoding, code-legality function, and next-code function.
REQ-033 Dwell counter SHALL be a sub-module width_enum_dwell (inputs: clear, enable, H; output: wrap).
REQ-034 All other logic SHALL reside in width_enum_seq; no latches; is_e2 is the only combinational output path.

Verification
REQ-035 Reset then start with hold_len=2, no stall -> code_out 0,0,5,5,6,6,7,7,A,A over cycles n+1..n+10; done at n+11.
REQ-036 hold_len=0, start -> each code held 1 cycle, done at n+6, is_e2 high exactly 1 cycle.
REQ-037 hold_len=3, stall for 4 cycles during E1 -> E1 visible 7 cycles total; done delayed by 4.
REQ-038 During E1, load_valid with code 4'hA -> E4 next cycle, E4 dwell of H cycles, then done; with code 4'h3 -> err=1, code_out=0, busy=0 until next start.
REQ-039 Assert rst during E2 -> all outputs at reset values immediately, no done pulse; a subsequent start restarts at E0.
